alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the combinational ALU decode: decodes opcode/funct3/funct7, executes the op and returns a registered result over a valid/ready handshake.
//  Adds RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) via an iterative shift-add / restoring-divide datapath; also adds SRA, SLT(U), BLTU, BGEU.
//  Sits in EX between operand muxes and EX/MEM; pipeline stalls on in_ready=0.
// PARAMETERS
//  XLEN      32  operand/result width (>=8, power of 2)
//  MD_ENABLE 1   1: decode M-ext; 0: M-ext funct7=0000001 treated as illegal (result 0)
// PORTS
//  clk         in   1     rising-edge clock
//  reset_n     in   1     async active-low reset
//  flush       in   1     abort in-flight op, return to IDLE
//  force_add   in   1     1: ignore decode, do ADD (addr calc / PC+4)
//  in_valid    in   1     request valid
//  in_ready    out  1     request accepted when in_valid&in_ready
//  opcode      in   7     instruction opcode
//  funct3      in   3     instruction funct3
//  funct7      in   7     instruction funct7
//  op_a        in   XLEN  rs1 / PC
//  op_b        in   XLEN  rs2 / immediate
//  out_valid   out  1     result valid; held until out_ready
//  out_ready   in   1     consumer accepts result
//  result      out  XLEN  ALU/MUL/DIV result
//  bcond       out  1     branch taken (BRANCH only, else 0)
//  busy        out  1     multi-cycle op in CALC/FIX
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; out_valid=0, result=0, bcond=0, busy=0; in_ready=1 after release.
//  FSM: IDLE, CALC, FIX, DONE. in_ready = IDLE | (DONE & out_ready).
//  Accept of single-cycle op (ALU, ALU-imm, LOAD/STORE/JAL/JALR add, BRANCH, force_add): -> DONE; out_valid next cycle (latency 1).
//  Accept of M-ext op (opcode ARITHMETIC, funct7=0000001, MD_ENABLE=1): -> CALC; XLEN iterations, one per cycle, then FIX (sign correction, special cases), then DONE; out_valid exactly XLEN+2 cycles after accept, independent of operands.
//  DONE: result/bcond held stable while out_valid & !out_ready; DONE & out_ready & in_valid starts the next op in the same cycle; DONE & out_ready & !in_valid -> IDLE.
//  force_add overrides all decode: result = op_a+op_b, single-cycle.
//  ARITHMETIC funct7[5]: ADD/SUB, SRL/SRA; ARITHMETIC_IMM: funct7[5] honoured only for SRAI (ADDI never subtracts).
//  Shifts use op_b[log2(XLEN)-1:0]. SLT/SLTU result = {XLEN-1 zeros, flag}.
//  BRANCH: BEQ/BNE/BLT/BGE/BLTU/BGEU set bcond; result = 0; illegal funct3 -> bcond=0.
//  Unknown opcode/funct combination: result=0, bcond=0, single-cycle (never hangs).
//  MUL: low XLEN bits; MULH/MULHSU/MULHU: high XLEN bits of 2*XLEN product with signed/unsigned per RV spec.
//  DIV/REM truncate toward zero; sign of REM follows dividend.
//  Divide by zero: DIV/DIVU = all ones, REM/REMU = op_a.
//  Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV = op_a, REM = 0.
//  Special cases still take full XLEN+2 latency.
//  Operands latched on accept; input changes after accept have no effect.
//  flush: any state -> IDLE next edge, out_valid=0; flush & in_valid in the same cycle: request not accepted.
//  Async reset mid-CALC: immediate IDLE, partial product discarded.
// TESTING
//  ADD 5+7, then SUB 5-7 (funct7=0100000) -> out_valid 1 cycle after each accept; result 12, then 0xFFFFFFFE.
//  SRAI op_a=0x80000000, shamt 4 -> 0xF8000000; SRLI same -> 0x08000000.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; out_valid exactly 34 cycles after accept.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7.
//  BLTU 1 vs 0xFFFFFFFF -> bcond=1; BLT same operands -> bcond=0; out_ready held low 5 cycles -> result stable, in_ready=0.
//  DIV started, flush at cycle 10 -> no out_valid, in_ready=1 next cycle; reset_n pulse mid-CALC -> all outputs 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with RV32I ALU/branch decode and iterative RV32M multiply/divide; single-cycle ops answer 1 cycle after accept, M-ext ops XLEN+2 cycles after accept.
// Result is held in DONE until out_ready; in_ready only in IDLE or when DONE is being drained, so a stalled consumer stalls the pipeline.
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter bit MD_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            force_add,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            bcond,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_result;
  logic            r_bcond;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_a;
  logic [2:0]      r_f3;
  logic            r_negq;
  logic            r_negr;
  logic            r_divz;
  logic [SHW-1:0]  r_cnt;

  logic            w_accept;
  logic            w_is_md;
  logic            w_imm_ok;
  logic            w_sa;
  logic            w_sb;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_sc_res;
  logic            w_sc_bcond;
  logic [XLEN:0]   w_msum;
  logic [XLEN+1:0] w_trial;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_fix_res;

  function automatic logic [XLEN-1:0] alu_f(input logic [2:0] f3, input logic alt,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SHW-1:0]         sh;
    logic signed [XLEN-1:0] sra;
    sh  = b[SHW-1:0];
    sra = $signed(a) >>> sh;
    case (f3)
      3'b000:  alu_f = alt ? (a - b) : (a + b);
      3'b001:  alu_f = a << sh;
      3'b010:  alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  alu_f = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu_f = a ^ b;
      3'b101: begin
        if (alt) alu_f = sra;
        else     alu_f = a >> sh;
      end
      3'b110:  alu_f = a | b;
      default: alu_f = a & b;
    endcase
  endfunction

  function automatic logic br_f(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b);
    case (f3)
      3'b000:  br_f = (a == b);
      3'b001:  br_f = (a != b);
      3'b100:  br_f = ($signed(a) < $signed(b));
      3'b101:  br_f = ($signed(a) >= $signed(b));
      3'b110:  br_f = (a < b);
      3'b111:  br_f = (a >= b);
      default: br_f = 1'b0;
    endcase
  endfunction

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC) || (r_state == S_FIX);
  assign result    = r_result;
  assign bcond     = r_bcond;

  assign w_is_md  = MD_ENABLE && !force_add && (opcode == OPC_OP) && (funct7 == F7_MD);
  assign w_imm_ok = (funct3 == 3'b001) ? (funct7 == F7_BASE) :
                    (funct3 == 3'b101) ? ((funct7 == F7_BASE) || (funct7 == F7_ALT)) : 1'b1;

  // Signedness per M-ext funct3: MULH/DIV/REM both signed, MULHSU only rs1.
  assign w_sa    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sb    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg = w_sa && op_a[XLEN-1];
  assign w_b_neg = w_sb && op_b[XLEN-1];
  assign w_abs_a = w_a_neg ? (-op_a) : op_a;
  assign w_abs_b = w_b_neg ? (-op_b) : op_b;

  always_comb begin
    w_sc_res   = '0;
    w_sc_bcond = 1'b0;
    if (force_add) begin
      w_sc_res = op_a + op_b;
    end else begin
      case (opcode)
        OPC_OP: begin
          if ((funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))))
            w_sc_res = alu_f(funct3, funct7[5], op_a, op_b);
        end
        OPC_IMM: begin
          if (w_imm_ok)
            w_sc_res = alu_f(funct3, (funct3 == 3'b101) && funct7[5], op_a, op_b);
        end
        OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: w_sc_res = op_a + op_b;
        OPC_BRANCH: w_sc_bcond = br_f(funct3, op_a, op_b);
        default: ;
      endcase
    end
  end

  // Iteration step: shift-add multiply on magnitudes, restoring divide on magnitudes.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_trial = {1'b0, r_hi, r_lo[XLEN-1]} - {2'b00, r_mcand};

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_negq ? (-w_prod) : w_prod;

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (r_divz)      w_fix_res = '1;
        else if (r_negq) w_fix_res = -r_lo;
        else             w_fix_res = r_lo;
      end
      default: begin
        if (r_divz)      w_fix_res = r_a;
        else if (r_negr) w_fix_res = -r_hi;
        else             w_fix_res = r_hi;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_bcond  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_a      <= '0;
      r_f3     <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_divz   <= 1'b0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_CALC: begin
          r_cnt <= r_cnt + SHW'(1);
          if (&r_cnt) r_state <= S_FIX;
          if (r_f3[2]) begin
            if (!w_trial[XLEN+1]) begin
              r_hi <= w_trial[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
              r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
              r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_msum[XLEN:1];
            r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_bcond  <= 1'b0;
          r_state  <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            if (w_is_md) begin
              r_state <= S_CALC;
              r_cnt   <= '0;
              r_f3    <= funct3;
              r_hi    <= '0;
              r_lo    <= funct3[2] ? w_abs_a : w_abs_b;
              r_mcand <= funct3[2] ? w_abs_b : w_abs_a;
              r_negq  <= w_a_neg ^ w_b_neg;
              r_negr  <= w_a_neg;
              r_divz  <= (op_b == '0);
              r_a     <= op_a;
            end else begin
              r_state  <= S_DONE;
              r_result <= w_sc_res;
              r_bcond  <= w_sc_bcond;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] IMM    = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset_n, flush, force_add, in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        out_valid, out_ready, bcond, busy;

  int errors = 0;
  int checks = 0;

  logic [6:0] opc_tab [8] = '{OP, IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI};

  alu_exec_unit #(.XLEN(32), .MD_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .force_add(force_add),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .bcond(bcond), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit fa, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic bc, output int lat);
    logic [63:0] sa, sb, za, zb, p;
    int sh;
    bit legal, alt;
    r = '0; bc = 1'b0; lat = 1; sh = int'(b[4:0]);
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    za = {32'b0, a};       zb = {32'b0, b};
    if (fa) begin
      r = a + b;
    end else if (opc == OP && f7 == 7'h01) begin
      lat = 34;
      case (f3)
        3'd0: begin p = za * zb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * zb; r = p[63:32]; end
        3'd3: begin p = za * zb; r = p[63:32]; end
        3'd4: begin
          if (b == 0) r = 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
          else r = $signed(a) / $signed(b);
        end
        3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) r = a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
          else r = $signed(a) % $signed(b);
        end
        default: r = (b == 0) ? a : a % b;
      endcase
    end else if (opc == OP || opc == IMM) begin
      if (opc == OP) begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        alt   = (f7 == 7'h20);
      end else begin
        legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        alt   = (f3 == 3'd5) && (f7 == 7'h20);
      end
      if (legal) begin
        case (f3)
          3'd0: r = alt ? a - b : a + b;
          3'd1: r = a << sh;
          3'd2: r = {31'b0, $signed(a) < $signed(b)};
          3'd3: r = {31'b0, a < b};
          3'd4: r = a ^ b;
          3'd5: begin
            if (alt) r = $signed(a) >>> sh;
            else     r = a >> sh;
          end
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
    end else if (opc == LOAD || opc == STORE || opc == JAL || opc == JALR) begin
      r = a + b;
    end else if (opc == BRANCH) begin
      case (f3)
        3'd0: bc = (a == b);
        3'd1: bc = (a != b);
        3'd4: bc = ($signed(a) < $signed(b));
        3'd5: bc = ($signed(a) >= $signed(b));
        3'd6: bc = (a < b);
        3'd7: bc = (a >= b);
        default: bc = 1'b0;
      endcase
    end
  endfunction

  task automatic run_op(input string tag, input bit fa, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        eb;
    int          el, cyc;
    model(fa, opc, f3, f7, a, b, er, eb, el);
    force_add = fa; opcode = opc; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    chk({tag, ":in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    force_add = 1'($urandom); opcode = 7'($urandom); funct3 = 3'($urandom);
    funct7 = 7'($urandom); op_a = $urandom; op_b = $urandom;
    if (hold > 0) out_ready = 1'b0;
    cyc = 1;
    if (el > 1) chk({tag, ":busy"}, 64'(busy), 64'(1));
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ":latency"}, 64'(cyc), 64'(el));
    chk({tag, ":result"}, 64'(result), 64'(er));
    chk({tag, ":bcond"}, 64'(bcond), 64'(eb));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
      chk({tag, ":hold_result"}, 64'(result), 64'(er));
      chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    if (hold > 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ":drained"}, 64'(out_valid), 64'(0));
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'(($urandom_range(0, 9)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    reset_n = 1'b0; flush = 1'b0; force_add = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_bcond", 64'(bcond), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    #20 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    run_op("add",    0, OP,     3'd0, 7'h00, 32'd5,        32'd7,        0);
    run_op("sub",    0, OP,     3'd0, 7'h20, 32'd5,        32'd7,        0);
    run_op("srai",   0, IMM,    3'd5, 7'h20, 32'h80000000, 32'd4,        0);
    run_op("srli",   0, IMM,    3'd5, 7'h00, 32'h80000000, 32'd4,        0);
    run_op("addi",   0, IMM,    3'd0, 7'h20, 32'd5,        32'd7,        0);
    run_op("mulh",   0, OP,     3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mulhu",  0, OP,     3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("div_ov", 0, OP,     3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("rem_ov", 0, OP,     3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("divu_0", 0, OP,     3'd5, 7'h01, 32'd7,        32'd0,        0);
    run_op("remu_0", 0, OP,     3'd7, 7'h01, 32'd7,        32'd0,        0);
    run_op("div_0",  0, OP,     3'd4, 7'h01, 32'hFFFFFFF9, 32'd0,        0);
    run_op("bltu",   0, BRANCH, 3'd6, 7'h00, 32'd1,        32'hFFFFFFFF, 0);
    run_op("blt",    0, BRANCH, 3'd4, 7'h00, 32'd1,        32'hFFFFFFFF, 5);
    run_op("forced", 1, BRANCH, 3'd0, 7'h01, 32'h100,      32'h4,        0);
    run_op("bad_op", 0, LUI,    3'd0, 7'h00, 32'd3,        32'd4,        0);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      run_op("rand", ($urandom_range(0, 15) == 0), opc_tab[$urandom_range(0, 7)],
             3'($urandom), f7, rnd_val(), rnd_val(),
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end

    // Flush a divide mid-calculation, then offer a request together with flush.
    run_op("pre_flush", 0, OP, 3'd0, 7'h00, 32'd1, 32'd2, 0);
    opcode = OP; funct3 = 3'd4; funct7 = 7'h01; op_a = 32'd100; op_b = 32'd7; force_add = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_busy_before", 64'(busy), 64'(1));
    flush = 1'b1; in_valid = 1'b1; opcode = OP; funct3 = 3'd0; funct7 = 7'h00;
    @(posedge clk); #1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("flush_no_accept", 64'(out_valid), 64'(0));
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_stale", 64'(seen), 64'(0));

    // Asynchronous reset in the middle of a multiply.
    run_op("pre_reset", 0, BRANCH, 3'd0, 7'h00, 32'd9, 32'd9, 0);
    opcode = OP; funct3 = 3'd0; funct7 = 7'h01; op_a = 32'd1234; op_b = 32'd77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_result", 64'(result), 64'(0));
    chk("mid_rst_bcond", 64'(bcond), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    run_op("post_rst_mulhsu", 0, OP, 3'd2, 7'h01, 32'hFFFFFFFE, 32'hFFFFFFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
